// File: rtl/sq_sum.sv
// sq_sum: computes y = a*a + b*b using shift-and-add over 16 cycles.
// The adder is outside this block and is shared: the block presents two
// operands (reg1/reg2) and takes back their 17-bit sum in the same cycle.
module sq_sum (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  a_bi,
    input  logic [7:0]  b_bi,
    input  logic        start_i,
    output logic        ready,
    output logic        busy_o,
    output logic [16:0] y_bo,
    output logic [16:0] summator_reg1_sqsum,
    output logic [16:0] summator_reg2_sqsum,
    input  logic [16:0] summator_result_sqsum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ_A = 2'd1,
        SQ_B = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q,   idx_d;
    logic [16:0] acc_q,   acc_d;
    logic [7:0]  a_q,     a_d;
    logic [7:0]  b_q,     b_d;
    logic [16:0] y_q,     y_d;

    // The operand being squared: a during SQ_A, b during SQ_B.
    logic [7:0]  op_sel;
    logic [16:0] op_shifted;
    logic        op_bit;

    assign op_sel     = (state_q == SQ_B) ? b_q : a_q;
    assign op_shifted = {9'b0, op_sel} << idx_q;
    assign op_bit     = op_sel[idx_q];

    assign ready  = (state_q == IDLE);
    assign busy_o = ~ready;
    assign y_bo   = y_q;

    // State register and datapath registers; synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            acc_q   <= 17'd0;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            y_q     <= 17'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
        end
    end

    // Next-state logic and adder operand selection.
    always_comb begin
        state_d             = state_q;
        idx_d               = idx_q;
        acc_d               = acc_q;
        a_d                 = a_q;
        b_d                 = b_q;
        y_d                 = y_q;
        summator_reg1_sqsum = 17'd0;
        summator_reg2_sqsum = 17'd0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_bi;
                    b_d     = b_bi;
                    acc_d   = 17'd0;
                    idx_d   = 3'd0;
                    state_d = SQ_A;
                end
            end
            SQ_A, SQ_B: begin
                // Add the shifted operand only where its bit idx is set.
                summator_reg1_sqsum = acc_q;
                summator_reg2_sqsum = op_bit ? op_shifted : 17'd0;
                acc_d               = summator_result_sqsum;
                idx_d               = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    if (state_q == SQ_A) begin
                        state_d = SQ_B;
                    end else begin
                        // acc keeps running from a*a into b*b; last sum is the result.
                        state_d = IDLE;
                        y_d     = summator_result_sqsum;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sq_sum.sv
// Directed testbench for sq_sum with a model of the external adder.
module tb_sq_sum;

    logic        clk_i;
    logic        rst_i;
    logic [7:0]  a_bi;
    logic [7:0]  b_bi;
    logic        start_i;
    logic        ready;
    logic        busy_o;
    logic [16:0] y_bo;
    logic [16:0] summator_reg1_sqsum;
    logic [16:0] summator_reg2_sqsum;
    logic [16:0] summator_result_sqsum;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;
    logic [16:0] hold_y;

    sq_sum dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .a_bi                  (a_bi),
        .b_bi                  (b_bi),
        .start_i               (start_i),
        .ready                 (ready),
        .busy_o                (busy_o),
        .y_bo                  (y_bo),
        .summator_reg1_sqsum   (summator_reg1_sqsum),
        .summator_reg2_sqsum   (summator_reg2_sqsum),
        .summator_result_sqsum (summator_result_sqsum)
    );

    // External shared adder: 17-bit wrap-around sum.
    assign summator_result_sqsum = summator_reg1_sqsum + summator_reg2_sqsum;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // busy_o must be the inverse of ready on every cycle.
    always @(negedge clk_i) begin
        if (mon_en) chk("busy_inv", {31'b0, busy_o}, {31'b0, ~ready});
    end

    // One operation; inj_cycle pulses a stray start, abort_cycle asserts reset.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [16:0] exp_y,
                          input int inj_cycle, input int abort_cycle);
        logic [16:0] exp_acc;
        logic [16:0] term;
        logic [7:0]  op;
        int          idx;
        a_bi    = a;
        b_bi    = b;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        a_bi    = ~a;          // later operand changes must not matter
        b_bi    = ~b;
        exp_acc = 17'd0;
        for (int k = 0; k < 16; k++) begin
            if (k == inj_cycle) begin
                start_i = 1'b1;
                a_bi    = 8'd10;
                b_bi    = 8'd10;
            end
            if (k == abort_cycle) begin
                rst_i   = 1'b0;
                start_i = 1'b1;
            end
            op   = (k < 8) ? a : b;
            idx  = k % 8;
            term = op[idx] ? ({9'b0, op} << idx) : 17'd0;
            @(negedge clk_i);
            chk("busy_work", {31'b0, busy_o}, 32'd1);
            chk("reg1_acc",  {15'b0, summator_reg1_sqsum}, {15'b0, exp_acc});
            chk("reg2_term", {15'b0, summator_reg2_sqsum}, {15'b0, term});
            chk("y_hold",    {15'b0, y_bo}, {15'b0, hold_y});
            exp_acc = exp_acc + term;
            @(posedge clk_i); #1;
            start_i = 1'b0;
            if (k == abort_cycle) begin
                rst_i = 1'b1;
                chk("abort_ready", {31'b0, ready}, 32'd1);
                chk("abort_busy",  {31'b0, busy_o}, 32'd0);
                chk("abort_y",     {15'b0, y_bo}, 32'd0);
                hold_y = 17'd0;
                $display("op a=%0d b=%0d aborted at cycle %0d, y=%0d", a, b, k, y_bo);
                return;
            end
        end
        chk("done_ready", {31'b0, ready}, 32'd1);
        chk("done_y",     {15'b0, y_bo}, {15'b0, exp_y});
        chk("idle_reg1",  {15'b0, summator_reg1_sqsum}, 32'd0);
        chk("idle_reg2",  {15'b0, summator_reg2_sqsum}, 32'd0);
        hold_y = exp_y;
        $display("op a=%0d b=%0d -> y=%0d (expect %0d)", a, b, y_bo, exp_y);
    endtask

    initial begin
        rst_i   = 1'b0;
        start_i = 1'b1;        // must be ignored while in reset
        a_bi    = 8'd77;
        b_bi    = 8'd33;
        hold_y  = 17'd0;
        repeat (3) @(posedge clk_i);
        #1;
        mon_en = 1'b1;
        @(negedge clk_i);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_busy",  {31'b0, busy_o}, 32'd0);
        chk("rst_y",     {15'b0, y_bo}, 32'd0);
        chk("rst_reg1",  {15'b0, summator_reg1_sqsum}, 32'd0);
        chk("rst_reg2",  {15'b0, summator_reg2_sqsum}, 32'd0);
        $display("reset: ready=%0d busy=%0d y=%0d", ready, busy_o, y_bo);
        @(posedge clk_i); #1;
        rst_i   = 1'b1;
        start_i = 1'b0;
        @(posedge clk_i); #1;

        run_op(8'd3,   8'd4,   17'd25,     -1, -1);
        run_op(8'd255, 8'd255, 17'd130050, -1, -1);
        run_op(8'd255, 8'd0,   17'd65025,  -1, -1);
        run_op(8'd0,   8'd0,   17'd0,      -1, -1);
        // Stray start mid-operation is ignored.
        run_op(8'd3,   8'd4,   17'd25,      5, -1);
        // Reset in the middle of an operation aborts it.
        run_op(8'd200, 8'd100, 17'd0,      -1,  8);
        run_op(8'd1,   8'd1,   17'd2,      -1, -1);
        // Back-to-back: second start on the first ready cycle.
        run_op(8'd6,   8'd8,   17'd100,    -1, -1);
        run_op(8'd5,   8'd12,  17'd169,    -1, -1);

        repeat (2) @(posedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
